// File: rtl/regfile_pkg.sv
// Shared defaults and FSM state encoding for the multi-read-port register file.
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int N_RD_DEF   = 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_t;
endpackage

// File: rtl/regfile_clr_fsm.sv
// Post-reset clear sequencer: sweeps every entry to zero once, then reports ready.
// INIT lasts exactly 2**ADDR_W cycles after rst deasserts; no backpressure.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_ptr
);

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] ptr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      clr_ptr <= '0;
    end else begin
      state_q <= state_d;
      clr_ptr <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = clr_ptr;
    clr_we  = 1'b0;
    ready   = 1'b0;
    case (state_q)
      INIT: begin
        clr_we = !rst;
        ptr_d  = clr_ptr + 1'b1;
        if (clr_ptr == '1) state_d = RUN;
      end
      RUN: ready = 1'b1;
      default: state_d = INIT;
    endcase
  end

endmodule

// File: rtl/regfile_mp.sv
// Register file: one write port, N_RD registered read ports with write-first bypass.
// Read latency 1 cycle; no backpressure, all ports idle (reads return 0) until ready.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int N_RD     = N_RD_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [N_RD-1:0]          rd_en,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  output logic                     ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_ptr;
  logic              user_we;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_q [N_RD];

  regfile_clr_fsm #(.ADDR_W(ADDR_W)) u_clr (
    .clk     (clk),
    .rst     (rst),
    .ready   (ready),
    .clr_we  (clr_we),
    .clr_ptr (clr_ptr)
  );

  assign user_we   = ready && wr_en && !rst && !(ZR && (wr_addr == '0));
  assign mem_we    = clr_we || user_we;
  assign mem_waddr = clr_we ? clr_ptr : wr_addr;
  assign mem_wdata = clr_we ? '0 : wr_data;

  // Single write port and no reset on the array keeps it mappable to distributed RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  for (genvar g = 0; g < N_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = rd_addr[g*ADDR_W +: ADDR_W];

    always_ff @(posedge clk) begin
      if (rst || !ready) begin
        rd_q[g] <= '0;
      end else if (rd_en[g]) begin
        if (ZR && (ra == '0))            rd_q[g] <= '0;
        else if (wr_en && ra == wr_addr) rd_q[g] <= wr_data;
        else                             rd_q[g] <= mem[ra];
      end
    end

    assign rd_data[g*DATA_W +: DATA_W] = rd_q[g];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: reference model feeds an expected-result queue each cycle.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [NR-1:0]     rd_en;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic              ready;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic          rdy;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_rd  [NR];
  logic          m_run;
  int            m_ptr;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .ZERO_REG(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .ready   (ready)
  );

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance the model by one edge using the currently driven inputs.
  task automatic model_step();
    logic [AW-1:0] a;
    exp_t e;
    if (rst) begin
      m_run = 1'b0;
      m_ptr = 0;
      for (int i = 0; i < NR; i++) m_rd[i] = '0;
    end else if (!m_run) begin
      m_mem[m_ptr] = '0;
      if (m_ptr == DEPTH - 1) m_run = 1'b1;
      m_ptr++;
      for (int i = 0; i < NR; i++) m_rd[i] = '0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (rd_en[i]) begin
          a = rd_addr[i*AW +: AW];
          if (a == 0)                          m_rd[i] = '0;
          else if (wr_en && a == wr_addr)      m_rd[i] = wr_data;
          else                                 m_rd[i] = m_mem[a];
        end
      end
      if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
    end
    e.d0  = m_rd[0];
    e.d1  = m_rd[1];
    e.rdy = m_run;
    exp_q.push_back(e);
  endtask

  task automatic cycle();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val("rd0", rd_data[DW-1:0], e.d0);
    check_val("rd1", rd_data[2*DW-1:DW], e.d1);
    check_val("ready", {31'b0, ready}, {31'b0, e.rdy});
  endtask

  task automatic set_rd(input logic [NR-1:0] en, input int a0, input int a1);
    rd_en   = en;
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic set_wr(input logic en, input int a, input logic [DW-1:0] d);
    wr_en   = en;
    wr_addr = AW'(a);
    wr_data = d;
  endtask

  // Runs the clear sweep with stray traffic driven, measures its length.
  task automatic run_init(input string tag);
    int cnt;
    bit done;
    cnt  = 0;
    done = 0;
    set_wr(1'b1, 3, 32'hBAD0_BAD0);
    set_rd(2'b11, 3, 5);
    for (int i = 0; i < 100 && !done; i++) begin
      cycle();
      cnt++;
      if (ready) done = 1;
    end
    check_val(tag, DW'(cnt), DW'(DEPTH));
    set_wr(1'b0, 0, '0);
    set_rd(2'b00, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    set_wr(1'b0, 0, '0);
    set_rd(2'b00, 0, 0);
    cycle();
    check_val("rst_rd0", rd_data[DW-1:0], 32'h0);
    check_val("rst_ready", {31'b0, ready}, 32'h0);
    rst = 1'b0;
    run_init("init_len");

    // Every entry cleared by the sweep
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(2'b11, a, DEPTH - 1 - a);
      cycle();
      check_val("clr_rd0", rd_data[DW-1:0], 32'h0);
      check_val("clr_rd1", rd_data[2*DW-1:DW], 32'h0);
    end
    set_rd(2'b00, 0, 0);

    // Write then read r5
    set_wr(1'b1, 5, 32'hDEADBEEF);
    cycle();
    set_wr(1'b0, 0, '0);
    set_rd(2'b01, 5, 0);
    cycle();
    check_val("r5_read", rd_data[DW-1:0], 32'hDEADBEEF);

    // Port 0 holds while disabled and its address moves
    set_rd(2'b00, 9, 0);
    cycle();
    set_rd(2'b00, 17, 0);
    cycle();
    check_val("hold_rd0", rd_data[DW-1:0], 32'hDEADBEEF);

    // Same-cycle bypass on both ports
    set_wr(1'b1, 7, 32'h12345678);
    set_rd(2'b11, 7, 7);
    cycle();
    check_val("byp_rd0", rd_data[DW-1:0], 32'h12345678);
    check_val("byp_rd1", rd_data[2*DW-1:DW], 32'h12345678);

    // Zero register: write discarded, bypass suppressed
    set_wr(1'b1, 0, 32'hFFFFFFFF);
    set_rd(2'b11, 0, 0);
    cycle();
    check_val("z_byp_rd0", rd_data[DW-1:0], 32'h0);
    check_val("z_byp_rd1", rd_data[2*DW-1:DW], 32'h0);
    set_wr(1'b0, 0, '0);
    cycle();
    check_val("z_rd0", rd_data[DW-1:0], 32'h0);
    check_val("z_rd1", rd_data[2*DW-1:DW], 32'h0);

    // Reset mid-RUN wipes r3; the write coincident with rst is dropped
    set_wr(1'b1, 3, 32'hA5A5A5A5);
    set_rd(2'b00, 0, 0);
    cycle();
    set_wr(1'b0, 0, '0);
    set_rd(2'b10, 0, 3);
    cycle();
    check_val("r3_pre", rd_data[2*DW-1:DW], 32'hA5A5A5A5);
    rst = 1'b1;
    set_wr(1'b1, 4, 32'h0BAD_F00D);
    cycle();
    check_val("rst2_rd1", rd_data[2*DW-1:DW], 32'h0);
    rst = 1'b0;
    run_init("init_len2");
    set_rd(2'b11, 3, 4);
    cycle();
    check_val("r3_post", rd_data[DW-1:0], 32'h0);
    check_val("r4_post", rd_data[2*DW-1:DW], 32'h0);

    // Random traffic on a narrow address window to provoke collisions
    for (int i = 0; i < 300; i++) begin
      set_wr(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom);
      set_rd(2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, 7));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
